// File: rtl/rcm_pkg.sv
// Shared types, drain word indices and a saturating adder for reg_capture_monitor.
package rcm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int                IDX_W     = 2;
    localparam logic [IDX_W-1:0]  WORD_CYC  = 2'd0;
    localparam logic [IDX_W-1:0]  WORD_TOG  = 2'd1;
    localparam logic [IDX_W-1:0]  WORD_MAX  = 2'd2;
    localparam int                NUM_WORDS = 3;

    // Add b to a and clamp at maxv; a is assumed already <= maxv.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] maxv);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, maxv}) begin
            return maxv;
        end else begin
            return sum[63:0];
        end
    endfunction

endpackage

// File: rtl/reg_capture_monitor_if.sv
// Valid/ready drain port carrying the three statistics words.
interface rcm_drain_if #(
    parameter int CNT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_last, output out_ready);
endinterface

// File: rtl/popcount_tree.sv
// Combinational count of bits that differ between the D and Q buses.
module popcount_tree #(
    parameter int WIDTH = 64,
    parameter int POP_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] q_in,
    output logic [POP_W-1:0] pop
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0] diff_s;
    logic [POP_W-1:0]  node_s [LEAVES];

    // Toggle mask padded with zeros up to a power-of-two leaf count.
    always_comb begin
        diff_s = LEAVES'(d_in ^ q_in);
    end

    // Pairwise adder tree, reduced in place one level at a time.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            node_s[i] = POP_W'(diff_s[i]);
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < (LEAVES >> (l + 1)); i++) begin
                node_s[i] = node_s[2*i] + node_s[2*i+1];
            end
        end
    end

    assign pop = node_s[0];

endmodule

// File: rtl/reg_capture_monitor.sv
// Counts per-cycle bit toggles of a watched register and drains three
// run statistics (cycles, total toggles, peak toggles) over valid/ready.
module reg_capture_monitor
    import rcm_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32,
    parameter int POP_W = $clog2(WIDTH + 1)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    rcm_drain_if.master      drain
);

    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] cyc_cnt_r, cyc_nxt_s;
    logic [CNT_W-1:0] tog_cnt_r, tog_nxt_s;
    logic [POP_W-1:0] max_tog_r, max_nxt_s;
    logic [IDX_W-1:0] word_idx_r, idx_nxt_s;
    logic [POP_W-1:0] pop_s;
    logic             hs_s;
    logic             last_hs_s;
    logic [CNT_W-1:0] word_sel_s;

    logic             out_valid_r;
    logic             out_last_r;
    logic [CNT_W-1:0] out_data_r;
    logic             busy_r;
    logic             done_r;

    popcount_tree #(
        .WIDTH (WIDTH),
        .POP_W (POP_W)
    ) u_popcount (
        .d_in (d_in),
        .q_in (q_in),
        .pop  (pop_s)
    );

    assign hs_s      = (state_r == DRAIN) && drain.out_ready;
    assign last_hs_s = hs_s && (word_idx_r == IDX_W'(NUM_WORDS - 1));

    // Next state, next accumulator values and next drain index.
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = cyc_cnt_r;
        tog_nxt_s   = tog_cnt_r;
        max_nxt_s   = max_tog_r;
        idx_nxt_s   = word_idx_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    cyc_nxt_s   = '0;
                    tog_nxt_s   = '0;
                    max_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                // The stop cycle itself still counts when sampled.
                if (sample_en) begin
                    cyc_nxt_s = CNT_W'(sat_add(64'(cyc_cnt_r), 64'd1, CNT_MAX));
                    tog_nxt_s = CNT_W'(sat_add(64'(tog_cnt_r), 64'(pop_s), CNT_MAX));
                    max_nxt_s = (pop_s > max_tog_r) ? pop_s : max_tog_r;
                end else begin
                    cyc_nxt_s = cyc_cnt_r;
                end
                if (stop) begin
                    state_nxt_s = DRAIN;
                    idx_nxt_s   = WORD_CYC;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (last_hs_s) begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = WORD_CYC;
                end else if (hs_s) begin
                    idx_nxt_s   = word_idx_r + 2'd1;
                end else begin
                    idx_nxt_s   = word_idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Word presented after the coming edge, chosen from next-cycle values.
    always_comb begin
        word_sel_s = '0;
        case (idx_nxt_s)
            WORD_CYC: word_sel_s = cyc_nxt_s;
            WORD_TOG: word_sel_s = tog_nxt_s;
            WORD_MAX: word_sel_s = CNT_W'(max_nxt_s);
            default:  word_sel_s = '0;
        endcase
    end

    // State, accumulators and drain index.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_r    <= IDLE;
            cyc_cnt_r  <= '0;
            tog_cnt_r  <= '0;
            max_tog_r  <= '0;
            word_idx_r <= WORD_CYC;
        end else begin
            state_r    <= state_nxt_s;
            cyc_cnt_r  <= cyc_nxt_s;
            tog_cnt_r  <= tog_nxt_s;
            max_tog_r  <= max_nxt_s;
            word_idx_r <= idx_nxt_s;
        end
    end

    // Registered outputs, aligned with the state they describe.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == DRAIN);
            out_last_r  <= (state_nxt_s == DRAIN) && (idx_nxt_s == WORD_MAX);
            out_data_r  <= (state_nxt_s == DRAIN) ? word_sel_s : '0;
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= last_hs_s;
        end
    end

    assign drain.out_valid = out_valid_r;
    assign drain.out_last  = out_last_r;
    assign drain.out_data  = out_data_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: tb/tb_reg_capture_monitor.sv
// Scoreboard bench for reg_capture_monitor, with a CNT_W=8 twin for saturation.
module tb_reg_capture_monitor;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        sample_en = 1'b0;
    logic [63:0] d_in = 64'd0;
    logic [63:0] q_in = 64'd0;
    logic        out_ready = 1'b1;
    logic        busy, done, busy8, done8;

    rcm_drain_if #(.CNT_W(32)) bus  ();
    rcm_drain_if #(.CNT_W(8))  bus8 ();
    assign bus.out_ready  = out_ready;
    assign bus8.out_ready = out_ready;

    reg_capture_monitor #(.WIDTH(64), .CNT_W(32)) dut (
        .CK(CK), .RN(RN), .start(start), .stop(stop), .sample_en(sample_en),
        .d_in(d_in), .q_in(q_in), .busy(busy), .done(done), .drain(bus)
    );

    reg_capture_monitor #(.WIDTH(64), .CNT_W(8)) dut8 (
        .CK(CK), .RN(RN), .start(start), .stop(stop), .sample_en(sample_en),
        .d_in(d_in), .q_in(q_in), .busy(busy8), .done(done8), .drain(bus8)
    );

    always #5 CK = ~CK;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_run   = 1'b0;
    longint      m_cyc, m_tog, m_max;
    logic [31:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    function automatic longint satl(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle with d^q = x; the model follows the expected FSM.
    task automatic drive(input logic s, input logic p, input logic en, input logic [63:0] x);
        q_in      = {$urandom, $urandom};
        d_in      = q_in ^ x;
        start     = s;
        stop      = p;
        sample_en = en;
        if (!m_run) begin
            if (s) begin
                m_run = 1'b1;
                m_cyc = 0; m_tog = 0; m_max = 0;
            end
        end else begin
            if (en) begin
                m_cyc = m_cyc + 1;
                m_tog = m_tog + $countones(x);
                if ($countones(x) > m_max) m_max = $countones(x);
            end
            if (p) begin
                m_run = 1'b0;
                exp_q.push_back(32'(satl(m_cyc, 64'hFFFF_FFFF)));
                exp_q.push_back(32'(satl(m_tog, 64'hFFFF_FFFF)));
                exp_q.push_back(32'(m_max));
                exp8_q.push_back(8'(satl(m_cyc, 64'd255)));
                exp8_q.push_back(8'(satl(m_tog, 64'd255)));
                exp8_q.push_back(8'(m_max));
            end
        end
        @(negedge CK);
        start = 1'b0; stop = 1'b0; sample_en = 1'b0;
    endtask

    // Drain both DUTs against the scoreboard, optionally stalling one word.
    task automatic drain_collect(input int stall_idx, input int stall_len, input int exp_done, input string tag);
        int  widx = 0;
        int  stalled = 0;
        int  cnt = 0;
        bit  got_done = 1'b0;
        bit  stall;
        while (!got_done && cnt < 40) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                stall = (widx == stall_idx) && (stalled < stall_len);
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus8.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s valid w%0d: got %b/%b want 1", tag, widx, bus.out_valid, bus8.out_valid);
                end
                n_tests++;
                if (exp_q.size() == 0 || exp8_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra word w%0d: got %0d, none expected", tag, widx, bus.out_data);
                end else if (bus.out_data !== exp_q[0] || bus8.out_data !== exp8_q[0]) begin
                    n_fail++;
                    $display("FAIL %s data w%0d: got %0d/%0d want %0d/%0d", tag, widx,
                             bus.out_data, bus8.out_data, exp_q[0], exp8_q[0]);
                end
                n_tests++;
                if (bus.out_last !== (widx == 2) || bus8.out_last !== (widx == 2)) begin
                    n_fail++;
                    $display("FAIL %s last w%0d: got %b want %b", tag, widx, bus.out_last, (widx == 2));
                end
                if (stall) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    if (exp_q.size() != 0)  void'(exp_q.pop_front());
                    if (exp8_q.size() != 0) void'(exp8_q.pop_front());
                    widx++;
                end
                @(negedge CK);
                cnt++;
            end
        end
        out_ready = 1'b1;
        n_tests++;
        if (!got_done || cnt != exp_done || done8 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done latency: got %0d cycles (done=%b done8=%b) want %0d", tag, cnt, done, done8, exp_done);
        end
        @(negedge CK);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post-done: got done=%b busy=%b valid=%b want 0/0/0", tag, done, busy, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        repeat (3) @(negedge CK);
        n_tests++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0 || bus.out_data !== 32'd0 ||
            busy8 !== 1'b0 || bus8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state: got busy=%b valid=%b done=%b data=%0d want 0", busy, bus.out_valid, done, bus.out_data);
        end
        RN = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset first start: got busy=%b want 1", busy);
        end
        // Stop cycle is sampled: one cycle, 3 toggles.
        drive(1'b0, 1'b1, 1'b1, 64'h7);
        drain_collect(-1, 0, 3, "stop_sampled");
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 64'hF);
        drive(1'b0, 1'b0, 1'b1, 64'h1);
        drive(1'b0, 1'b0, 1'b1, {64{1'b1}});
        drive(1'b0, 1'b1, 1'b0, 64'd0);
        drain_collect(-1, 0, 3, "basic");
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 64'hF);
        drive(1'b0, 1'b0, 1'b1, 64'h1);
        drive(1'b0, 1'b0, 1'b1, {64{1'b1}});
        drive(1'b0, 1'b1, 1'b0, 64'd0);
        drain_collect(1, 5, 8, "backpressure");
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b1, {64{1'b1}});
        drive(1'b0, 1'b1, 1'b0, 64'd0);
        drain_collect(-1, 0, 3, "saturation");
    endtask

    task automatic test_precedence();
        drive(1'b0, 1'b1, 1'b0, 64'd0);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop in idle: got busy=%b want 0", busy);
        end
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        n_tests++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start+stop idle: got busy=%b valid=%b want 1/0", busy, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, {$urandom, $urandom});
        drive(1'b0, 1'b0, 1'b1, 64'h1F);
        drive(1'b0, 1'b0, 1'b1, 64'h1F);
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        drain_collect(-1, 0, 3, "precedence");
    endtask

    task automatic test_reset_middrain();
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 64'hFF);
        drive(1'b0, 1'b0, 1'b1, 64'hFF);
        drive(1'b0, 1'b1, 1'b0, 64'd0);
        out_ready = 1'b1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL middrain word0: got valid=%b data=%0d want 1/2", bus.out_valid, bus.out_data);
        end
        @(negedge CK);
        n_tests++;
        if (bus.out_data !== 32'd16) begin
            n_fail++;
            $display("FAIL middrain word1: got %0d want 16", bus.out_data);
        end
        out_ready = 1'b0;
        RN = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL middrain abort: got valid=%b busy=%b want 0/0", bus.out_valid, busy);
        end
        exp_q.delete();
        exp8_q.delete();
        m_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CK);
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL middrain done in reset: got %b want 0", done);
            end
        end
        RN = 1'b1;
        out_ready = 1'b1;
        @(negedge CK);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL middrain after release: got done=%b busy=%b want 0/0", done, busy);
        end
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 64'h3);
        drive(1'b0, 1'b1, 1'b0, 64'd0);
        drain_collect(-1, 0, 3, "fresh_run");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_precedence();
        test_reset_middrain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_capture_monitor.md
Name: reg_capture_monitor

Overview:
- Observes one WIDTH-bit pipeline register by watching its D (next state) and Q (current state) buses.
- Each sampled cycle, it counts how many bits the register is about to change at the coming capture edge.
- It accumulates three run statistics: sampled cycles, total toggling bits, and peak toggles in one cycle.
- It drains the statistics as three words over a valid/ready port.
- It is the synthesizable readout end of the FPU's per-register capture-activity instrumentation, and sits beside the 64-bit FPU datapath registers.

Parameters:
- WIDTH, 64, bit width of the observed register.
- CNT_W, 32, width of each accumulator and of out_data; must be at least POP_W.
- POP_W, $clog2(WIDTH+1), derived; popcount width (7 for WIDTH=64).

Ports:
- CK  in  1  clock; all state updates on rising edge.
- RN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clear the statistics and begin counting.
- stop  in  1  one-cycle pulse; end counting and begin the drain.
- sample_en  in  1  qualifies the current cycle for counting.
- d_in  in  WIDTH  D bus of the observed register.
- q_in  in  WIDTH  Q bus of the observed register.
- out_valid  out  1  a drain word is presented.
- out_ready  in  1  consumer accepts the word.
- out_data  out  CNT_W  drain word.
- out_last  out  1  high with the final (third) word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (RN=0, asynchronous):
  - State goes to IDLE.
  - cyc_cnt, tog_cnt, max_tog and the word index clear to 0.
  - Outputs out_valid, out_data, out_last, busy and done are all 0.
  - Reset mid-RUN or mid-DRAIN aborts immediately: no done pulse, and partial statistics are lost.
- State machine (IDLE, RUN, DRAIN):
  - IDLE --start--> RUN. On this edge all three accumulators clear. The start cycle itself is not sampled.
  - RUN --stop--> DRAIN. The stop cycle is sampled if sample_en=1. The word index is set to 0.
  - DRAIN --(handshake on word 2)--> IDLE. done=1 for exactly the following cycle.
- Event precedence:
  - stop in IDLE or DRAIN is ignored.
  - start in RUN or DRAIN is ignored.
  - start and stop together in IDLE: start wins and the state enters RUN.
  - start and stop together in RUN: stop wins and the state enters DRAIN.
- Counting (RUN only, sample_en=1), with p = popcount(d_in ^ q_in), width POP_W:
  - cyc_cnt is incremented by 1, saturating at 2^CNT_W-1.
  - tog_cnt += p (p zero-extended), saturating at 2^CNT_W-1 with no wrap.
  - max_tog = max(max_tog, p).
  - A cycle with sample_en=0 changes nothing.
- Drain:
  - out_valid=1 throughout DRAIN.
  - out_data is driven from registers: word 0 = cyc_cnt, word 1 = tog_cnt, word 2 = max_tog zero-extended.
  - A word transfers when out_valid & out_ready; the index then advances on the next edge.
  - out_data and out_last hold stable while out_ready=0.
  - out_last=1 only while word 2 is presented.
  - Accumulators are not modified in DRAIN. They retain their values in IDLE until the next start.
- Latency:
  - Word 0 is valid in the cycle after stop is registered.
  - With out_ready held high, the drain takes 3 cycles, and done appears in the 4th cycle.
- busy is a registered view of state != IDLE.

Decomposition:
- Package rcm_pkg holds:
  - the state typedef (IDLE, RUN, DRAIN);
  - word index constants WORD_CYC=0, WORD_TOG=1, WORD_MAX=2, NUM_WORDS=3;
  - a saturating-add helper function.
- Sub-module popcount_tree (WIDTH -> POP_W) is purely combinational: an adder tree over d_in ^ q_in.
- The top level holds the FSM, the accumulators and the output registers.

Test Plan:
- Reset: hold RN=0, then release.
  -> busy=0, out_valid=0, done=0, out_data=0.
  -> The first cycle after release accepts start.
- Basic run: start, then three sample_en cycles with d^q = 0xF, 0x1 and all-ones (64 bits), then stop, with out_ready=1.
  -> Words are 3, 69, 64.
  -> out_last is set on 64.
  -> done pulses once, then busy=0.
- Backpressure: same run, with out_ready=0 for 5 cycles while word 1 is presented.
  -> out_data holds 69 and out_valid stays 1 for all 5 cycles.
  -> Completion is 5 cycles later than in the basic run.
- Saturation (CNT_W=8): 300 sample cycles with d^q all-ones.
  -> Words are 255, 255, 64.
  -> No wrap occurs.
- Gating and precedence:
  - start and stop in the same IDLE cycle -> busy=1, state RUN.
  - 4 cycles with sample_en=0, then 2 sampled cycles with p=5, then start and stop together -> words 2, 10, 5.
- Reset mid-drain: assert RN while word 1 is presented.
  -> out_valid drops immediately and done never pulses.
  -> After release, a fresh run reports only its own counts.
